pipe_de_skid: RTL and testbench
===============================

Name: pipe_de_skid

Overview:
- Parametrised successor to the decode/execute pipeline register.
- Carries the control bundle, opcode, destination, operands A/B, immediate and N vector lanes from decode to execute.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a downstream stall does not lose data and full throughput is kept.
- Adds synchronous flush, bubble-safe control outputs, async active-low reset, and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 32, width of operands, immediate and each lane
- LANES, 32, number of vector lanes carried
- CTRL_W, 11, width of the packed control bundle (layout in pipe_pkg)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- cnt_clr  in  1  synchronous clear of both counters
- in_valid  in  1  decode presents an entry
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  CTRL_W  control bundle: ALU code, result mux, write-dir mux, mem-dir mux, data mux, WriteMem, WriteReg
- in_opcode  in  5  opcode
- in_dst  in  5  destination register
- in_val_a  in  DATA_W  operand A
- in_val_b  in  DATA_W  operand B
- in_imm  in  DATA_W  immediate/shift value
- in_lanes  in  LANES*DATA_W  lane data, lane k at [k*DATA_W +: DATA_W]
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes
- out_ctrl, out_opcode, out_dst, out_val_a, out_val_b, out_imm, out_lanes  out  same widths  held entry
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready
- bubble_cnt  out  CNT_W  cycles with ~out_valid

Behaviour:
- Storage: main register (drives outputs) plus skid register.
- accept = in_valid & in_ready & ~flush
- take = out_valid & out_ready
- States:
  - EMPTY: main invalid, skid invalid
  - BUSY: main valid, skid invalid
  - FULL: main valid, skid valid
- in_ready = ~skid_valid, registered. It is 1 in EMPTY and BUSY, 0 in FULL.
- Transitions:
  - EMPTY + accept -> BUSY; main <= input.
  - BUSY + accept & take -> BUSY; main <= input.
  - BUSY + accept & ~take -> FULL; skid <= input; main holds.
  - BUSY + ~accept & take -> EMPTY.
  - FULL + take -> BUSY; main <= skid. No accept is possible in FULL.
  - Otherwise hold. Held payload must not change while out_valid & ~out_ready.
- Latency: 1 cycle from accept in EMPTY to out_valid.
- Ordering: strict FIFO order, no duplication, no loss.
- flush (highest priority): next state EMPTY, both entries discarded, an input presented in the same cycle is dropped, and take is ignored. Next cycle: out_valid=0, in_ready=1.
- Bubble safety: when out_valid=0, out_ctrl, out_opcode and out_dst are driven 0. WriteMem/WriteReg therefore never assert on a bubble. Data outputs may hold stale values.
- Counters:
  - Increment per the port definitions and saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr zeroes both counters; if it coincides with an increment event, the counter reads 0.
  - flush does not clear the counters.
- Reset (rst_n=0, asynchronous):
  - State EMPTY, out_valid=0, in_ready=1.
  - All payload registers 0, all outputs 0, both counters 0.
  - Reset asserted mid-transfer discards every entry; the first accept after release behaves as from EMPTY.

Decomposition:
- pipe_pkg holds:
  - CTRL_W
  - field offsets: ALU_CODE [3:0], MUX_RESULT [5:4], MUX_DIR_WRITE [6], MUX_DIR_MEM [7], MUX_DATO [8], WRITE_MEM [9], WRITE_REG [10]
  - OPCODE_W=5, REG_ADDR_W=5
  - state encoding: EMPTY=2'b00, BUSY=2'b01, FULL=2'b11
- Sub-module pipe_skid_core: generic PAYLOAD_W skid buffer with handshake, flush and counters.
- Top packs the fields into one payload, unpacks it, and applies bubble gating.

Test Plan:
- Reset, then in_valid=1 every cycle, out_ready=1, dst=1..8 -> out_dst 1..8 one cycle later each, in_ready held 1, stall_cnt=0.
- Accept dst=3, out_ready=0 for 3 cycles while dst=4 is offered -> FULL after 1 cycle, in_ready=0, out_dst stays 3, stall_cnt=3; out_ready=1 -> dst 3 then 4, no loss.
- In FULL with ctrl WRITE_REG=1, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears.
- CNT_W=4, out_ready=0 for 20 cycles after one accept -> stall_cnt saturates at 15; cnt_clr pulse -> 0.
- LANES=4, DATA_W=8, in_lanes=32'hDDCC_BBAA -> lane 2 of out_lanes = 8'hCC one cycle after accept.
- rst_n dropped asynchronously mid-FULL (between clock edges) -> out_valid=0 and all outputs 0 immediately, counters 0; the first accept after release yields latency 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute skid pipeline register:
// control bundle layout, field widths and the skid buffer state encoding.
package pipe_pkg;

    // Packed control bundle width and field positions
    localparam int CTRL_W            = 11;
    localparam int ALU_CODE_LSB      = 0;
    localparam int ALU_CODE_W        = 4;
    localparam int MUX_RESULT_LSB    = 4;
    localparam int MUX_RESULT_W      = 2;
    localparam int MUX_DIR_WRITE_BIT = 6;
    localparam int MUX_DIR_MEM_BIT   = 7;
    localparam int MUX_DATO_BIT      = 8;
    localparam int WRITE_MEM_BIT     = 9;
    localparam int WRITE_REG_BIT     = 10;

    // Instruction field widths
    localparam int OPCODE_W   = 5;
    localparam int REG_ADDR_W = 5;

    // Bit 0 marks the main entry valid, bit 1 marks the skid entry valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_core.sv
// Generic two-entry skid buffer: valid/ready handshake with a registered
// in_ready, synchronous flush and saturating stall/bubble counters.
module pipe_skid_core
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 cnt_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    skid_state_t          state;
    skid_state_t          state_n;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 in_ready_q;
    logic                 accept;
    logic                 take;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q & ~flush;
    assign take      = out_valid & out_ready;

    // Next-state and load selection; flush overrides everything and drops any input
    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n      = BUSY;
                        load_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && take) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_n   = FULL;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_n        = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            in_ready_q <= (state_n != FULL);
        end
    end

    // Payload registers: main feeds the outputs, skid catches the entry accepted during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Stall counter: cycles where execute holds off a valid entry, saturating, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Bubble counter: cycles with no valid entry toward execute, saturating, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_de_skid.sv
// Decode/execute pipeline register with skid buffer: packs the decode fields
// into one payload, and forces control/opcode/destination to 0 on bubbles.
module pipe_de_skid #(
    parameter int DATA_W = 32,
    parameter int LANES  = 32,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           cnt_clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CTRL_W-1:0]              in_ctrl,
    input  logic [pipe_pkg::OPCODE_W-1:0]  in_opcode,
    input  logic [pipe_pkg::REG_ADDR_W-1:0] in_dst,
    input  logic [DATA_W-1:0]              in_val_a,
    input  logic [DATA_W-1:0]              in_val_b,
    input  logic [DATA_W-1:0]              in_imm,
    input  logic [LANES*DATA_W-1:0]        in_lanes,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CTRL_W-1:0]              out_ctrl,
    output logic [pipe_pkg::OPCODE_W-1:0]  out_opcode,
    output logic [pipe_pkg::REG_ADDR_W-1:0] out_dst,
    output logic [DATA_W-1:0]              out_val_a,
    output logic [DATA_W-1:0]              out_val_b,
    output logic [DATA_W-1:0]              out_imm,
    output logic [LANES*DATA_W-1:0]        out_lanes,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               bubble_cnt
);

    localparam int PAYLOAD_W = CTRL_W + pipe_pkg::OPCODE_W + pipe_pkg::REG_ADDR_W
                             + 3 * DATA_W + LANES * DATA_W;

    logic [PAYLOAD_W-1:0]             in_payload;
    logic [PAYLOAD_W-1:0]             out_payload;
    logic [CTRL_W-1:0]                held_ctrl;
    logic [pipe_pkg::OPCODE_W-1:0]    held_opcode;
    logic [pipe_pkg::REG_ADDR_W-1:0]  held_dst;

    assign in_payload = {in_ctrl, in_opcode, in_dst, in_val_a, in_val_b, in_imm, in_lanes};
    assign {held_ctrl, held_opcode, held_dst, out_val_a, out_val_b, out_imm, out_lanes} = out_payload;

    pipe_skid_core #(
        .PAYLOAD_W (PAYLOAD_W),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_payload),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // Bubble gating so WriteMem/WriteReg can never fire from a stale entry
    always_comb begin
        out_ctrl   = '0;
        out_opcode = '0;
        out_dst    = '0;
        if (out_valid) begin
            out_ctrl   = held_ctrl;
            out_opcode = held_opcode;
            out_dst    = held_dst;
        end
    end

endmodule

// File: tb/tb_pipe_de_skid.sv
// Directed bench for pipe_de_skid with small lanes and a 4-bit counter so
// saturation and lane placement are visible in a short run.
module tb_pipe_de_skid;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      flush;
    logic                      cnt_clr;
    logic                      in_valid;
    logic                      in_ready;
    logic [CTRL_W-1:0]         in_ctrl;
    logic [4:0]                in_opcode;
    logic [4:0]                in_dst;
    logic [DATA_W-1:0]         in_val_a;
    logic [DATA_W-1:0]         in_val_b;
    logic [DATA_W-1:0]         in_imm;
    logic [LANES*DATA_W-1:0]   in_lanes;
    logic                      out_valid;
    logic                      out_ready;
    logic [CTRL_W-1:0]         out_ctrl;
    logic [4:0]                out_opcode;
    logic [4:0]                out_dst;
    logic [DATA_W-1:0]         out_val_a;
    logic [DATA_W-1:0]         out_val_b;
    logic [DATA_W-1:0]         out_imm;
    logic [LANES*DATA_W-1:0]   out_lanes;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          bubble_cnt;

    int checks;
    int passes;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic [4:0]  dst;
        logic [10:0] ctrl;
        logic        exp_valid;
        logic        exp_ready;
        logic [4:0]  exp_dst;
        logic [10:0] exp_ctrl;
        logic [3:0]  exp_stall;
    } vec_t;

    vec_t vecs[$];

    pipe_de_skid #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_opcode  (in_opcode),
        .in_dst     (in_dst),
        .in_val_a   (in_val_a),
        .in_val_b   (in_val_b),
        .in_imm     (in_imm),
        .in_lanes   (in_lanes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_opcode (out_opcode),
        .out_dst    (out_dst),
        .out_val_a  (out_val_a),
        .out_val_b  (out_val_b),
        .out_imm    (out_imm),
        .out_lanes  (out_lanes),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic iv, input logic ordy, input logic fl,
                                   input logic clr, input logic [4:0] dst,
                                   input logic [10:0] ctrl, input logic ev,
                                   input logic er, input logic [4:0] ed,
                                   input logic [10:0] ec, input logic [3:0] es);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.clr = clr; v.dst = dst; v.ctrl = ctrl;
        v.exp_valid = ev; v.exp_ready = er; v.exp_dst = ed; v.exp_ctrl = ec; v.exp_stall = es;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid  = v.iv;
        out_ready = v.ordy;
        flush     = v.fl;
        cnt_clr   = v.clr;
        in_dst    = v.dst;
        in_ctrl   = v.ctrl;
        in_opcode = v.dst ^ 5'h10;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        logic [4:0] exp_op;
        exp_op = v.exp_valid ? (v.exp_dst ^ 5'h10) : 5'h00;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_valid));
        checkOutput({tag, " in_ready"},  32'(in_ready),  32'(v.exp_ready));
        checkOutput({tag, " out_dst"},   32'(out_dst),   32'(v.exp_dst));
        checkOutput({tag, " out_ctrl"},  32'(out_ctrl),  32'(v.exp_ctrl));
        checkOutput({tag, " out_opcode"}, 32'(out_opcode), 32'(exp_op));
        checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), 32'(v.exp_stall));
    endtask

    initial begin
        vec_t idle;
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_opcode = '0;
        in_dst    = '0;
        in_val_a  = '0;
        in_val_b  = '0;
        in_imm    = '0;
        in_lanes  = '0;

        // Streaming at full rate, one entry per cycle
        vecs.push_back(mkVec(0, 1, 0, 1, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd0));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mkVec(1, 1, 0, 0, 5'(k), 11'h400 | 11'(k),
                                 1, 1, 5'(k), 11'h400 | 11'(k), 4'd0));
        end
        vecs.push_back(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd0));
        // Downstream stall fills the skid, then drains in order
        vecs.push_back(mkVec(1, 0, 0, 0, 5'd3, 11'h203, 1, 1, 5'd3, 11'h203, 4'd0));
        vecs.push_back(mkVec(1, 0, 0, 0, 5'd4, 11'h204, 1, 0, 5'd3, 11'h203, 4'd1));
        vecs.push_back(mkVec(0, 0, 0, 0, 5'd0, 11'h000, 1, 0, 5'd3, 11'h203, 4'd2));
        vecs.push_back(mkVec(0, 0, 0, 0, 5'd0, 11'h000, 1, 0, 5'd3, 11'h203, 4'd3));
        vecs.push_back(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 1, 1, 5'd4, 11'h204, 4'd3));
        vecs.push_back(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd3));
        // Flush while FULL with WriteReg set, input in the same cycle dropped
        vecs.push_back(mkVec(1, 0, 0, 0, 5'd5, 11'h400, 1, 1, 5'd5, 11'h400, 4'd3));
        vecs.push_back(mkVec(1, 0, 0, 0, 5'd6, 11'h401, 1, 0, 5'd5, 11'h400, 4'd4));
        vecs.push_back(mkVec(1, 1, 1, 0, 5'd7, 11'h407, 0, 1, 5'd0, 11'h000, 4'd4));
        vecs.push_back(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd4));
        vecs.push_back(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd4));

        // Reset state while rst_n is held low
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_dst", 32'(out_dst), 32'd0);
        checkOutput("reset stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            step();
            checkVector(i, vecs[i]);
        end

        // Lane placement and data operands, latency 1 from EMPTY
        idle = mkVec(0, 0, 0, 0, 5'd0, 11'h000, 0, 1, 5'd0, 11'h000, 4'd0);
        applyStimulus(mkVec(1, 1, 0, 0, 5'd2, 11'h3FF, 0, 0, 5'd0, 11'h000, 4'd0));
        in_opcode = 5'h1A;
        in_lanes  = 32'hDDCC_BBAA;
        in_val_a  = 8'h11;
        in_val_b  = 8'h22;
        in_imm    = 8'h33;
        step();
        checkOutput("lane2", 32'(out_lanes[2*DATA_W +: DATA_W]), 32'hCC);
        checkOutput("lane0", 32'(out_lanes[0 +: DATA_W]), 32'hAA);
        checkOutput("lane3", 32'(out_lanes[3*DATA_W +: DATA_W]), 32'hDD);
        checkOutput("val_a", 32'(out_val_a), 32'h11);
        checkOutput("val_b", 32'(out_val_b), 32'h22);
        checkOutput("imm", 32'(out_imm), 32'h33);
        checkOutput("opcode", 32'(out_opcode), 32'h1A);
        checkOutput("ctrl", 32'(out_ctrl), 32'h3FF);

        // Stall saturation; clear coinciding with an increment reads 0
        applyStimulus(idle);
        in_lanes = 32'h0;
        cnt_clr  = 1'b1;
        step();
        checkOutput("clr vs inc stall", 32'(stall_cnt), 32'd0);
        checkOutput("clr bubble", 32'(bubble_cnt), 32'd0);
        cnt_clr = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checkOutput($sformatf("stall sat %0d", i), 32'(stall_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        checkOutput("held lanes", 32'(out_lanes), 32'hDDCC_BBAA);
        checkOutput("held dst", 32'(out_dst), 32'd2);
        cnt_clr = 1'b1;
        step();
        checkOutput("stall clr", 32'(stall_cnt), 32'd0);
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("drain valid", 32'(out_valid), 32'd0);
        checkOutput("bubble while busy", 32'(bubble_cnt), 32'd0);
        for (int i = 0; i < 3; i++) step();
        checkOutput("bubble idle", 32'(bubble_cnt), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush keeps bubble", 32'(bubble_cnt), 32'd4);
        checkOutput("flush keeps stall", 32'(stall_cnt), 32'd0);

        // Asynchronous reset mid-FULL
        applyStimulus(mkVec(1, 0, 0, 0, 5'd10, 11'h600, 0, 0, 5'd0, 11'h000, 4'd0));
        in_lanes = 32'h1234_5678;
        in_val_a = 8'h5A;
        step();
        applyStimulus(mkVec(1, 0, 0, 0, 5'd11, 11'h600, 0, 0, 5'd0, 11'h000, 4'd0));
        step();
        checkOutput("pre-reset full in_ready", 32'(in_ready), 32'd0);
        checkOutput("pre-reset stall", 32'(stall_cnt), 32'd1);
        applyStimulus(idle);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async out_valid", 32'(out_valid), 32'd0);
        checkOutput("async in_ready", 32'(in_ready), 32'd1);
        checkOutput("async out_dst", 32'(out_dst), 32'd0);
        checkOutput("async out_ctrl", 32'(out_ctrl), 32'd0);
        checkOutput("async val_a", 32'(out_val_a), 32'd0);
        checkOutput("async lanes", 32'(out_lanes), 32'd0);
        checkOutput("async stall", 32'(stall_cnt), 32'd0);
        checkOutput("async bubble", 32'(bubble_cnt), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(mkVec(1, 1, 0, 0, 5'd12, 11'h400, 0, 0, 5'd0, 11'h000, 4'd0));
        step();
        checkOutput("post-reset valid", 32'(out_valid), 32'd1);
        checkOutput("post-reset dst", 32'(out_dst), 32'd12);
        applyStimulus(mkVec(0, 1, 0, 0, 5'd0, 11'h000, 0, 0, 5'd0, 11'h000, 4'd0));
        step();
        checkOutput("post-reset drain", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
